// File: rtl/param_entry_unit_pkg.sv
// Shared types and constants for the decimal parameter entry block.
package param_entry_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_RANGE  = 2'd1;
  localparam logic [1:0] ERR_CHAR   = 2'd2;
  localparam logic [1:0] ERR_DIGITS = 2'd3;

  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_9 = 8'h39;
  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] LF   = 8'h0A;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/param_entry_unit_if.sv
// Received-byte stream from uart_rx into the parameter entry block.
interface param_entry_unit_if;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/param_entry_unit_bank.sv
// Bank of NUM_CH parameter registers with one write port and a flat read bus.
module param_bank #(
  parameter int NUM_CH      = 4,
  parameter int VAL_W       = 8,
  parameter int DEFAULT_VAL = 10,
  parameter int CH_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [CH_W-1:0]         wch,
  input  logic [VAL_W-1:0]        wdata,
  output logic [NUM_CH*VAL_W-1:0] rdata
);

  logic [VAL_W-1:0] regs [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) regs[k] <= VAL_W'(DEFAULT_VAL);
    end else if (we) begin
      regs[wch] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) rdata[k*VAL_W +: VAL_W] = regs[k];
  end

endmodule

// File: rtl/param_entry_unit.sv
// ASCII decimal parameter entry: collects digits from the UART byte stream,
// range-checks the value and writes it to the channel selected at entry start.
module param_entry_unit
  import param_entry_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TIMEOUT_US  = 500,
  parameter int MAX_DIGITS  = 3,
  parameter int VAL_W       = 8,
  parameter int MIN_VAL     = 5,
  parameter int MAX_VAL     = 30,
  parameter int DEFAULT_VAL = 10,
  parameter int NUM_CH      = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  param_entry_unit_if.slave       rx,
  input  logic                    enable,
  input  logic [CH_W-1:0]         ch_sel,
  output logic [NUM_CH*VAL_W-1:0] param_value,
  output logic                    update_pulse,
  output logic [CH_W-1:0]         update_ch,
  output logic                    param_error,
  output logic [1:0]              err_code,
  output logic                    busy
);

  localparam int TIMEOUT_CNT = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int TMR_W       = $clog2(TIMEOUT_CNT);
  localparam int ACC_W       = $clog2(10 ** MAX_DIGITS);
  localparam int CNT_W       = $clog2(MAX_DIGITS + 1);

  state_t            state, state_next;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [TMR_W-1:0]  timer;
  logic [CH_W-1:0]   ch;
  logic              start, shift, tick, we, err_set;
  logic [1:0]        err_val;
  logic              rx_digit, rx_term, in_range;
  logic [ACC_W-1:0]  digit;

  assign rx_digit = rx.rx_valid && is_digit(rx.rx_data);
  assign rx_term  = rx.rx_valid && ((rx.rx_data == CR) || (rx.rx_data == LF));
  assign digit    = ACC_W'(rx.rx_data[3:0]);
  // Compare at full accumulator width so oversize entries are rejected, not wrapped.
  assign in_range = (acc >= ACC_W'(MIN_VAL)) && (acc <= ACC_W'(MAX_VAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift      = 1'b0;
    tick       = 1'b0;
    we         = 1'b0;
    err_set    = 1'b0;
    err_val    = ERR_NONE;
    unique case (state)
      IDLE: begin
        if (enable && rx_digit) begin
          start      = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (!enable)                                    state_next = IDLE;
        else if (rx_digit && cnt < CNT_W'(MAX_DIGITS))  shift = 1'b1;
        else if (rx_digit) begin
          err_set = 1'b1;
          err_val = ERR_DIGITS;
        end
        else if (rx_term)                               state_next = CHECK;
        else if (rx.rx_valid) begin
          err_set = 1'b1;
          err_val = ERR_CHAR;
        end
        else if (timer == TMR_W'(TIMEOUT_CNT - 1))      state_next = CHECK;
        else                                            tick = 1'b1;
      end
      CHECK: begin
        if (in_range) begin
          we         = 1'b1;
          state_next = DONE;
        end else begin
          err_set = 1'b1;
          err_val = ERR_RANGE;
        end
      end
      DONE, ERROR: begin
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (err_set) state_next = ERROR;
    param_error = (state == ERROR);
    busy        = (state == COLLECT) || (state == CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      timer        <= '0;
      ch           <= '0;
      err_code     <= ERR_NONE;
      update_pulse <= 1'b0;
      update_ch    <= '0;
    end else begin
      update_pulse <= we;
      if (start) begin
        acc      <= digit;
        cnt      <= CNT_W'(1);
        timer    <= '0;
        ch       <= ch_sel;
        err_code <= ERR_NONE;
      end
      if (shift) begin
        acc   <= ACC_W'(acc * ACC_W'(10) + digit);
        cnt   <= cnt + 1'b1;
        timer <= '0;
      end
      if (tick)    timer     <= timer + 1'b1;
      if (err_set) err_code  <= err_val;
      if (we)      update_ch <= ch;
    end
  end

  param_bank #(
    .NUM_CH      (NUM_CH),
    .VAL_W       (VAL_W),
    .DEFAULT_VAL (DEFAULT_VAL),
    .CH_W        (CH_W)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wch   (ch),
    .wdata (VAL_W'(acc)),
    .rdata (param_value)
  );

endmodule

// File: tb/tb_param_entry_unit.sv
// Bench for param_entry_unit: table of entry vectors checked through an event
// scoreboard, plus timed sequences for latency, timeout and reset corners.
module tb_param_entry_unit;
  import param_entry_pkg::*;

  localparam int NUM_CH = 4;
  localparam int VAL_W  = 8;
  localparam int CH_W   = 2;
  localparam int NV     = 9;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic [CH_W-1:0]         ch_sel;
  logic [NUM_CH*VAL_W-1:0] param_value;
  logic                    update_pulse;
  logic [CH_W-1:0]         update_ch;
  logic                    param_error;
  logic [1:0]              err_code;
  logic                    busy;

  always #5 clk = ~clk;

  param_entry_unit_if rx_bus ();

  param_entry_unit #(
    .CLK_FREQ   (1_000_000),
    .TIMEOUT_US (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx_bus.slave),
    .enable       (enable),
    .ch_sel       (ch_sel),
    .param_value  (param_value),
    .update_pulse (update_pulse),
    .update_ch    (update_ch),
    .param_error  (param_error),
    .err_code     (err_code),
    .busy         (busy)
  );

  typedef struct {
    logic       is_err;
    logic [1:0] ch;
    logic [7:0] val;
    logic [1:0] code;
  } exp_t;

  typedef struct {
    logic [1:0] ch;
    int         n;
    logic [7:0] b [5];
    logic       is_err;
    logic [7:0] val;
    logic [1:0] code;
  } vec_t;

  exp_t       sb [$];
  exp_t       e;
  vec_t       tv [NV];
  logic [7:0] shadow [NUM_CH];
  logic       err_seen = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic logic [7:0] chan(input int k);
    return param_value[k*VAL_W +: VAL_W];
  endfunction

  function automatic vec_t mk(input logic [1:0] ch, input string s, input logic is_err,
                              input logic [7:0] val, input logic [1:0] code);
    vec_t v;
    v.ch = ch;
    v.n  = s.len();
    for (int i = 0; i < 5; i++) v.b[i] = (i < s.len()) ? s[i] : 8'h00;
    v.is_err = is_err;
    v.val    = val;
    v.code   = code;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_bus.rx_valid = 1'b1;
    rx_bus.rx_data  = b;
    @(posedge clk);
    #1;
    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_data  = 8'h00;
  endtask

  task automatic expect_evt(input logic is_err, input logic [1:0] ch, input logic [7:0] val,
                            input logic [1:0] code);
    exp_t x;
    x.is_err = is_err;
    x.ch     = ch;
    x.val    = val;
    x.code   = code;
    sb.push_back(x);
    if (!is_err) shadow[ch] = val;
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
    chk(name, sb.size(), 0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_channels(input string name);
    for (int k = 0; k < NUM_CH; k++) chk($sformatf("%s_ch%0d", name, k), chan(k), shadow[k]);
  endtask

  task automatic wait_update(output int n);
    n = 0;
    while (update_pulse !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Scoreboard: every update strobe or rising param_error consumes one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (update_pulse === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_update: got ch %0d value %0d, expected no update",
                   update_ch, chan(int'(update_ch)));
        end else begin
          e = sb.pop_front();
          chk("event_is_err", 32'd0, {31'b0, e.is_err});
          if (!e.is_err) begin
            chk("update_ch", update_ch, e.ch);
            chk("update_value", chan(int'(e.ch)), e.val);
          end
        end
      end
      if (param_error === 1'b1 && !err_seen) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_error: got err_code %0d, expected no error", err_code);
        end else begin
          e = sb.pop_front();
          chk("event_is_err", 32'd1, {31'b0, e.is_err});
          if (e.is_err) chk("err_code", err_code, e.code);
        end
      end
    end
    err_seen = (param_error === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    tv[0] = mk(2'd2, "25\015",   1'b0, 8'd25, ERR_NONE);
    tv[1] = mk(2'd1, "31\012",   1'b1, 8'd0,  ERR_RANGE);
    tv[2] = mk(2'd3, "1A",       1'b1, 8'd0,  ERR_CHAR);
    tv[3] = mk(2'd0, "1234",     1'b1, 8'd0,  ERR_DIGITS);
    tv[4] = mk(2'd1, "009\015",  1'b0, 8'd9,  ERR_NONE);
    tv[5] = mk(2'd3, "300\015",  1'b1, 8'd0,  ERR_RANGE);
    tv[6] = mk(2'd0, "X5\015",   1'b0, 8'd5,  ERR_NONE);
    tv[7] = mk(2'd3, "030\012",  1'b0, 8'd30, ERR_NONE);
    tv[8] = mk(2'd2, "4\015",    1'b1, 8'd0,  ERR_RANGE);

    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_data  = 8'h00;
    enable = 1'b0;
    ch_sel = '0;
    rst_n  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) shadow[k] = 8'd10;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk_channels("reset");
    chk("reset_err_code", err_code, 0);
    chk("reset_busy", busy, 0);
    chk("reset_update_pulse", update_pulse, 0);
    chk("reset_param_error", param_error, 0);

    for (int i = 0; i < NV; i++) begin
      ch_sel = tv[i].ch;
      enable = 1'b1;
      expect_evt(tv[i].is_err, tv[i].ch, tv[i].val, tv[i].code);
      for (int j = 0; j < tv[i].n; j++) send(tv[i].b[j]);
      drain($sformatf("vec%0d_event", i));
      if (tv[i].is_err) begin
        chk($sformatf("vec%0d_error_held", i), param_error, 1);
        chk($sformatf("vec%0d_busy", i), busy, 0);
      end
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_error_clear", i), param_error, 0);
      chk($sformatf("vec%0d_err_code_hold", i), err_code, tv[i].code);
      chk_channels($sformatf("vec%0d", i));
    end

    // Enable drop mid-entry: no write, no error, err_code cleared by entry start.
    ch_sel = 2'd2;
    enable = 1'b1;
    send(CH_0 + 8'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    chk("abort_err_code_cleared", err_code, 0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_after", busy, 0);
    chk("abort_param_error", param_error, 0);
    repeat (25) @(posedge clk);
    #1;
    chk_channels("abort");

    // Terminator latency: CHECK the cycle after CR, update the cycle after that.
    ch_sel = 2'd1;
    enable = 1'b1;
    expect_evt(1'b0, 2'd1, 8'd18, ERR_NONE);
    send(CH_0 + 8'd1);
    send(CH_0 + 8'd8);
    send(CR);
    chk("cr_check_busy", busy, 1);
    chk("cr_check_no_pulse", update_pulse, 0);
    @(posedge clk);
    #1;
    chk("cr_pulse", update_pulse, 1);
    chk("cr_busy_at_pulse", busy, 0);
    chk("cr_value", chan(1), 18);
    @(posedge clk);
    #1;
    chk("cr_pulse_single", update_pulse, 0);
    drain("cr_event");
    enable = 1'b0;
    @(posedge clk);
    #1;

    // Timeout: update 22 cycles after the digit strobe (21 edges after its sampling edge).
    ch_sel = 2'd0;
    enable = 1'b1;
    expect_evt(1'b0, 2'd0, 8'd7, ERR_NONE);
    send(CH_0 + 8'd7);
    wait_update(n);
    chk("timeout_latency", n, 21);
    chk("timeout_busy", busy, 0);
    drain("timeout_event");
    enable = 1'b0;
    @(posedge clk);
    #1;

    // Digit in the exact timeout cycle is accepted and restarts the timer.
    ch_sel = 2'd3;
    enable = 1'b1;
    expect_evt(1'b0, 2'd3, 8'd12, ERR_NONE);
    send(CH_0 + 8'd1);
    repeat (19) @(posedge clk);
    #1;
    chk("boundary_busy", busy, 1);
    send(CH_0 + 8'd2);
    wait_update(n);
    chk("boundary_restart_latency", n, 21);
    drain("boundary_event");
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk_channels("boundary");

    // Asynchronous reset mid-entry restores defaults without a clock edge.
    ch_sel = 2'd1;
    enable = 1'b1;
    send(CH_0 + 8'd2);
    send(CH_0 + 8'd2);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NUM_CH; k++) shadow[k] = 8'd10;
    chk_channels("async_reset");
    chk("async_reset_busy", busy, 0);
    chk("async_reset_err_code", err_code, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(CR);
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_busy", busy, 0);
    chk_channels("post_reset");
    enable = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
